writeback_stage: RTL

Final pipeline stage, directly downstream of the memory stage. It consumes the registered `WB_*` bundle and the memory-fault flags. It selects and extends the writeback value, drives the register-file write port and issues PC redirects for taken branches and jumps. It also sequences the trap entry for ECALL and load/store faults and counts retired instructions.

---
 rtl/writeback_stage_pkg.sv | 42 ++++
 rtl/writeback_stage_if.sv | 42 ++++
 rtl/writeback_stage_load_extend.sv | 21 ++
 rtl/writeback_stage.sv | 109 ++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared constants for the writeback stage: RV64 opcodes, trap cause codes
// and trap-sequencer state encoding.
package writeback_stage_pkg;

  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] SYSTEM    = 7'b1110011;
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;

  localparam logic [63:0] CAUSE_LAM   = 64'd4;
  localparam logic [63:0] CAUSE_LAF   = 64'd5;
  localparam logic [63:0] CAUSE_SAM   = 64'd6;
  localparam logic [63:0] CAUSE_SAF   = 64'd7;
  localparam logic [63:0] CAUSE_ECALL = 64'd11;

  typedef enum logic [1:0] {
    TS_IDLE   = 2'd0,
    TS_SAVE   = 2'd1,
    TS_VECTOR = 2'd2
  } trap_state_e;

  // ECALL/EBREAK (SYSTEM with funct3 == 0) never produce a register result.
  function automatic logic writes_reg(input logic [6:0] opcode, input logic [2:0] funct3);
    logic wr;
    wr = 1'b0;
    case (opcode)
      LOAD, JAL, JALR, LUI, AUIPC, OP, OP_IMM, OP_32, OP_IMM_32: wr = 1'b1;
      SYSTEM:  wr = (funct3 != 3'b000);
      default: wr = 1'b0;
    endcase
    return wr;
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Memory-stage bundle in, register-file / fetch-redirect / trap-CSR signals out.
interface writeback_stage_if #(parameter int XLEN = 64);
  logic            WB_V;
  logic [31:0]     WB_IR;
  logic [XLEN-1:0] WB_NPC;
  logic [XLEN-1:0] WB_ALU_RESULT;
  logic [XLEN-1:0] WB_MEM_RESULT;
  logic [XLEN-1:0] WB_CSRFD;
  logic            WB_PC_MUX;
  logic            WB_ECALL;
  logic            MEM_LAM;
  logic            MEM_LAF;
  logic            MEM_SAM;
  logic            MEM_SAF;
  logic [XLEN-1:0] MTVEC;

  logic            RF_WE;
  logic [4:0]      RF_DR;
  logic [XLEN-1:0] RF_DATA;
  logic            PC_REDIRECT;
  logic [XLEN-1:0] PC_TARGET;
  logic            FLUSH;
  logic            WB_STALL;
  logic            CSR_TRAP_WE;
  logic [XLEN-1:0] MEPC;
  logic [XLEN-1:0] MCAUSE;
  logic [XLEN-1:0] INSTRET;

  modport master (
    output WB_V, WB_IR, WB_NPC, WB_ALU_RESULT, WB_MEM_RESULT, WB_CSRFD,
           WB_PC_MUX, WB_ECALL, MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF, MTVEC,
    input  RF_WE, RF_DR, RF_DATA, PC_REDIRECT, PC_TARGET, FLUSH, WB_STALL,
           CSR_TRAP_WE, MEPC, MCAUSE, INSTRET
  );

  modport slave (
    input  WB_V, WB_IR, WB_NPC, WB_ALU_RESULT, WB_MEM_RESULT, WB_CSRFD,
           WB_PC_MUX, WB_ECALL, MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF, MTVEC,
    output RF_WE, RF_DR, RF_DATA, PC_REDIRECT, PC_TARGET, FLUSH, WB_STALL,
           CSR_TRAP_WE, MEPC, MCAUSE, INSTRET
  );
endinterface

// File: rtl/writeback_stage_load_extend.sv
// Sign/zero extension of right-justified load data, selected by the load funct3.
module load_extend (
  input  logic [2:0]  funct3,
  input  logic [63:0] mem_data,
  output logic [63:0] ext_data
);

  always_comb begin
    ext_data = mem_data;  // LD and reserved encodings pass through
    case (funct3)
      3'b000:  ext_data = {{56{mem_data[7]}},  mem_data[7:0]};
      3'b001:  ext_data = {{48{mem_data[15]}}, mem_data[15:0]};
      3'b010:  ext_data = {{32{mem_data[31]}}, mem_data[31:0]};
      3'b100:  ext_data = {56'd0, mem_data[7:0]};
      3'b101:  ext_data = {48'd0, mem_data[15:0]};
      3'b110:  ext_data = {32'd0, mem_data[31:0]};
      default: ext_data = mem_data;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: writeback select, branch/jump redirect, three-cycle
// trap entry sequencer and retired-instruction counter.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              CLK,
  input  logic              RESET_N,
  writeback_stage_if.slave  bus
);

  localparam logic [1:0] IDLE   = TS_IDLE;
  localparam logic [1:0] SAVE   = TS_SAVE;
  localparam logic [1:0] VECTOR = TS_VECTOR;

  logic [1:0]      state_reg, state_next;
  logic            active_reg;
  logic [XLEN-1:0] instret_reg, mepc_reg, mcause_reg;
  logic [XLEN-1:0] cause_next;
  logic [XLEN-1:0] load_value, wb_value;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic            fault, in_idle, retire, take_trap, in_vector, redirect;
  logic            unused_bits;

  assign opcode      = bus.WB_IR[6:0];
  assign funct3      = bus.WB_IR[14:12];
  assign rd          = bus.WB_IR[11:7];
  assign unused_bits = ^{bus.WB_IR[31:15], bus.MTVEC[1:0]};

  load_extend u_load_extend (
    .funct3   (funct3),
    .mem_data (bus.WB_MEM_RESULT),
    .ext_data (load_value)
  );

  always_comb begin
    wb_value = bus.WB_ALU_RESULT;
    case (opcode)
      LOAD:      wb_value = load_value;
      JAL, JALR: wb_value = bus.WB_NPC;
      SYSTEM:    wb_value = bus.WB_CSRFD;
      default:   wb_value = bus.WB_ALU_RESULT;
    endcase
  end

  // active_reg holds the stage quiet until the first edge after reset release.
  assign fault     = bus.WB_V & (bus.WB_ECALL | bus.MEM_LAM | bus.MEM_LAF |
                                 bus.MEM_SAM | bus.MEM_SAF);
  assign in_idle   = active_reg && (state_reg == IDLE);
  assign retire    = in_idle && bus.WB_V && !fault;
  assign take_trap = in_idle && fault;
  assign in_vector = active_reg && (state_reg == VECTOR);
  assign redirect  = (retire && bus.WB_PC_MUX) || in_vector;

  always_comb begin
    cause_next = CAUSE_SAF;
    if (bus.WB_ECALL)    cause_next = CAUSE_ECALL;
    else if (bus.MEM_LAM) cause_next = CAUSE_LAM;
    else if (bus.MEM_LAF) cause_next = CAUSE_LAF;
    else if (bus.MEM_SAM) cause_next = CAUSE_SAM;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = take_trap ? SAVE : IDLE;
      SAVE:    state_next = VECTOR;
      VECTOR:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      active_reg  <= 1'b0;
      state_reg   <= IDLE;
      instret_reg <= '0;
      mepc_reg    <= '0;
      mcause_reg  <= '0;
    end else begin
      active_reg <= 1'b1;
      state_reg  <= state_next;
      if (retire) begin
        instret_reg <= instret_reg + 1'b1;
      end
      if (take_trap) begin
        mepc_reg   <= bus.WB_NPC - XLEN'(4);
        mcause_reg <= cause_next;
      end
    end
  end

  assign bus.RF_WE       = retire && writes_reg(opcode, funct3) && (rd != 5'd0);
  assign bus.RF_DR       = retire ? rd : 5'd0;
  assign bus.RF_DATA     = retire ? wb_value : '0;
  assign bus.PC_REDIRECT = redirect;
  assign bus.FLUSH       = redirect;
  assign bus.PC_TARGET   = in_vector ? {bus.MTVEC[XLEN-1:2], 2'b00} :
                           redirect  ? {bus.WB_ALU_RESULT[XLEN-1:1], 1'b0} : '0;
  assign bus.WB_STALL    = active_reg && (state_reg != IDLE);
  assign bus.CSR_TRAP_WE = active_reg && (state_reg == SAVE);
  assign bus.MEPC        = mepc_reg;
  assign bus.MCAUSE      = mcause_reg;
  assign bus.INSTRET     = instret_reg;

endmodule
